// File: rtl/cpu_board_pkg.sv
// Shared constants and helpers for the CPU board controller.
package cpu_board_pkg;

  // All segments off (active-low), dp included.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a} for hex digits 0..F; dp stays off here.
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // log2 of the run-mode period, saturated at the slowest allowed rate.
  function automatic int clamp_log2(input int rate, input int min_log2, input int max_log2);
    int l;
    l = min_log2 + rate;
    return (l > max_log2) ? max_log2 : l;
  endfunction

endpackage

// File: rtl/seg_scan8.sv
// 8-digit multiplexed hex display scanner with registered segment/select outputs.
module seg_scan8
  import cpu_board_pkg::*;
#(
  parameter int SCAN_LOG2 = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] word,
  input  logic        dp_on,
  output logic [7:0]  seg,
  output logic [7:0]  sel
);

  logic [SCAN_LOG2+2:0] scan_cnt;
  logic [2:0]           d;
  logic [3:0]           nib;
  logic [7:0]           seg_d;

  assign d   = scan_cnt[SCAN_LOG2+2 -: 3];
  assign nib = word[{d, 2'b00} +: 4];

  // Decode the current nibble; dp marks digit 7 when requested.
  always_comb begin
    seg_d = HEX_SEG[nib];
    if (dp_on && d == 3'd7) seg_d[7] = 1'b0;
  end

  // Scan counter and output registers; seg and sel update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      seg      <= SEG_BLANK;
      sel      <= 8'hFF;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      sel      <= ~(8'h01 << d);
      seg      <= seg_d;
    end
  end

endmodule

// File: rtl/cpu_board_ctrl.sv
// CPU clock-enable generator (divided free-run or debounced single-step),
// retired-cycle counter and debug-channel display mux.
module cpu_board_ctrl
  import cpu_board_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int MIN_LOG2     = 10,
  parameter int RATE_W       = 4,
  parameter int MAX_LOG2     = 26,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int SCAN_LOG2    = 16,
  localparam int CSW         = $clog2(NUM_CH + 1)
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 run_mode,
  input  logic                 step_btn,
  input  logic [RATE_W-1:0]    rate_sel,
  input  logic [CSW-1:0]       ch_sel,
  input  logic [NUM_CH*32-1:0] ch_data,
  output logic                 cpu_clk_en,
  output logic [31:0]          cycle_cnt,
  output logic [7:0]           o_seg,
  output logic [7:0]           o_sel
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]          run_s, btn_s;
  logic                run_on, step_mode;
  logic [DB_W-1:0]     db_cnt;
  logic                db_lvl, db_prev, db_rise;
  logic [MAX_LOG2-1:0] div_cnt, term;
  logic [31:0]         cyc_q, disp_d, disp_q;

  assign run_on    = run_s[1];
  assign step_mode = ~run_s[1];
  assign db_rise   = db_lvl & ~db_prev;
  assign cycle_cnt = cyc_q;

  // Terminal count for the selected (clamped) run-mode period.
  always_comb
    term = MAX_LOG2'((64'd1 << clamp_log2(int'(rate_sel), MIN_LOG2, MAX_LOG2)) - 64'd1);

  // Two-flop synchronisers for the slide switch and push button.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      run_s <= '0;
      btn_s <= '0;
    end else begin
      run_s <= {run_s[0], run_mode};
      btn_s <= {btn_s[0], step_btn};
    end
  end

  // Debouncer: level flips after DEBOUNCE_CYC consecutive disagreeing samples.
  // Runs in both modes so a press held across a mode switch never steps.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      db_cnt  <= '0;
      db_lvl  <= 1'b0;
      db_prev <= 1'b0;
    end else begin
      db_prev <= db_lvl;
      if (btn_s[1] != db_lvl) begin
        if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
          db_lvl <= ~db_lvl;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Clock-enable: divider in run mode (>= compare so a shorter period never
  // stalls), one pulse per debounced press in step mode with the divider parked.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      div_cnt    <= '0;
      cpu_clk_en <= 1'b0;
    end else if (run_on) begin
      if (div_cnt >= term) begin
        div_cnt    <= '0;
        cpu_clk_en <= 1'b1;
      end else begin
        div_cnt    <= div_cnt + 1'b1;
        cpu_clk_en <= 1'b0;
      end
    end else begin
      div_cnt    <= '0;
      cpu_clk_en <= db_rise;
    end
  end

  // Retired-cycle counter, wraps naturally.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)          cyc_q <= '0;
    else if (cpu_clk_en) cyc_q <= cyc_q + 32'd1;
  end

  // Channel select; ch_sel == NUM_CH shows the cycle counter, beyond shows 0.
  always_comb begin
    disp_d = 32'h0;
    for (int k = 0; k < NUM_CH; k++)
      if (ch_sel == CSW'(k)) disp_d = ch_data[k*32 +: 32];
    if (ch_sel == CSW'(NUM_CH)) disp_d = cyc_q;
  end

  // Register the display word once per cycle.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) disp_q <= '0;
    else        disp_q <= disp_d;
  end

  seg_scan8 #(.SCAN_LOG2(SCAN_LOG2)) u_scan (
    .clk   (clk_in),
    .rst_n (reset),
    .word  (disp_q),
    .dp_on (step_mode),
    .seg   (o_seg),
    .sel   (o_sel)
  );

endmodule

// File: tb/tb_cpu_board_ctrl.sv
// Directed bench for cpu_board_ctrl with shortened periods and debounce.
module tb_cpu_board_ctrl;

  localparam int NUM_CH = 2, MIN_LOG2 = 4, RATE_W = 4, MAX_LOG2 = 7;
  localparam int DEB = 8, SCAN_LOG2 = 4, CSW = 2;

  logic                 clk_in = 1'b0;
  logic                 reset, run_mode, step_btn;
  logic [RATE_W-1:0]    rate_sel;
  logic [CSW-1:0]       ch_sel;
  logic [NUM_CH*32-1:0] ch_data;
  logic                 cpu_clk_en;
  logic [31:0]          cycle_cnt;
  logic [7:0]           o_seg, o_sel;

  int errors = 0, checks = 0;

  cpu_board_ctrl #(
    .NUM_CH(NUM_CH), .MIN_LOG2(MIN_LOG2), .RATE_W(RATE_W), .MAX_LOG2(MAX_LOG2),
    .DEBOUNCE_CYC(DEB), .SCAN_LOG2(SCAN_LOG2)
  ) dut (
    .clk_in(clk_in), .reset(reset), .run_mode(run_mode), .step_btn(step_btn),
    .rate_sel(rate_sel), .ch_sel(ch_sel), .ch_data(ch_data),
    .cpu_clk_en(cpu_clk_en), .cycle_cnt(cycle_cnt), .o_seg(o_seg), .o_sel(o_sel)
  );

  always #5 clk_in = ~clk_in;

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
  endtask

  // Posedges until cpu_clk_en is seen; -1 on timeout.
  task automatic wait_pulse(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (cpu_clk_en) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic count_pulses(input int cyc, output int c);
    c = 0;
    repeat (cyc) begin
      @(negedge clk_in);
      if (cpu_clk_en) c++;
    end
  endtask

  task automatic wait_sel(input logic [7:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in);
      if (o_sel == v) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; run_mode = 1'b1; step_btn = 1'b0; rate_sel = '0; ch_sel = 2'd1;
    ch_data = {32'hDEADBEEF, 32'h00400000};
    repeat (2) @(negedge clk_in);
    checks++; if (cpu_clk_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", cpu_clk_en); end
    checks++; if (cycle_cnt !== 32'h0) begin errors++; $display("FAIL reset_cyc got=%h exp=0", cycle_cnt); end
    checks++; if (o_seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got=%h exp=ff", o_seg); end
    checks++; if (o_sel !== 8'hFF) begin errors++; $display("FAIL reset_sel got=%h exp=ff", o_sel); end
  endtask

  task automatic test_run_rate();
    int n;
    run_mode = 1'b1; rate_sel = 4'd0;
    reset = 1'b1;
    wait_pulse(100, n);
    checks++; if (n != 18) begin errors++; $display("FAIL run_first got=%0d exp=18", n); end
    for (int i = 2; i <= 10; i++) begin
      wait_pulse(100, n);
      checks++; if (n != 16) begin errors++; $display("FAIL run_period16 #%0d got=%0d exp=16", i, n); end
    end
    rate_sel = 4'd2;
    @(negedge clk_in);
    checks++; if (cycle_cnt !== 32'd10) begin errors++; $display("FAIL run_cyc10 got=%0d exp=10", cycle_cnt); end
    wait_pulse(200, n);
    checks++; if (n != 63) begin errors++; $display("FAIL run_period64 got=%0d exp=63", n); end
    wait_pulse(200, n);
    checks++; if (n != 64) begin errors++; $display("FAIL run_period64b got=%0d exp=64", n); end
    // divider now 0; advance to 50 then shorten the period
    repeat (50) @(negedge clk_in);
    rate_sel = 4'd0;
    wait_pulse(5, n);
    checks++; if (n != 1) begin errors++; $display("FAIL rate_shrink got=%0d exp=1", n); end
    wait_pulse(100, n);
    checks++; if (n != 16) begin errors++; $display("FAIL rate_shrink_next got=%0d exp=16", n); end
    rate_sel = 4'd15;
    wait_pulse(300, n);
    checks++; if (n != 128) begin errors++; $display("FAIL rate_clamp got=%0d exp=128", n); end
  endtask

  task automatic test_step_debounce();
    int n, c;
    run_mode = 1'b0; step_btn = 1'b0; rate_sel = 4'd0;
    do_reset();
    repeat (5) @(negedge clk_in);
    step_btn = 1'b1;
    repeat (5) @(negedge clk_in);
    step_btn = 1'b0;
    count_pulses(30, c);
    checks++; if (c != 0) begin errors++; $display("FAIL step_glitch got=%0d exp=0", c); end
    step_btn = 1'b1;
    wait_pulse(40, n);
    checks++; if (n != 11) begin errors++; $display("FAIL step_press got=%0d exp=11", n); end
    count_pulses(9, c);
    checks++; if (c != 0) begin errors++; $display("FAIL step_single got=%0d exp=0", c); end
    step_btn = 1'b0;
    count_pulses(40, c);
    checks++; if (c != 0) begin errors++; $display("FAIL step_release got=%0d exp=0", c); end
    checks++; if (cycle_cnt !== 32'd1) begin errors++; $display("FAIL step_cyc got=%0d exp=1", cycle_cnt); end
  endtask

  task automatic test_held_switch();
    int n, c;
    bit ok;
    run_mode = 1'b1; rate_sel = 4'd15; step_btn = 1'b1; ch_sel = 2'd3;
    do_reset();
    repeat (30) @(negedge clk_in);
    run_mode = 1'b0;
    count_pulses(60, c);
    checks++; if (c != 0) begin errors++; $display("FAIL held_switch got=%0d exp=0", c); end
    step_btn = 1'b0;
    count_pulses(30, c);
    checks++; if (c != 0) begin errors++; $display("FAIL held_release got=%0d exp=0", c); end
    step_btn = 1'b1;
    wait_pulse(40, n);
    checks++; if (n != 11) begin errors++; $display("FAIL held_repress got=%0d exp=11", n); end
    step_btn = 1'b0;
    count_pulses(200, c);
    checks++; if (c != 0) begin errors++; $display("FAIL step_idle got=%0d exp=0", c); end
    checks++; if (cycle_cnt !== 32'd1) begin errors++; $display("FAIL step_idle_cyc got=%0d exp=1", cycle_cnt); end
    wait_sel(8'h7F, ok);
    repeat (4) @(negedge clk_in);
    checks++; if (!ok || o_seg !== 8'h40) begin errors++; $display("FAIL dp_digit7 got=%h exp=40", o_seg); end
    wait_sel(8'hFE, ok);
    repeat (4) @(negedge clk_in);
    checks++; if (!ok || o_seg !== 8'hC0) begin errors++; $display("FAIL dp_digit0 got=%h exp=c0", o_seg); end
  endtask

  task automatic test_display();
    logic [7:0] exp_seg [8] = '{8'h8E, 8'h86, 8'h86, 8'h83, 8'hA1, 8'h88, 8'h86, 8'hA1};
    logic [7:0] es;
    bit ok, ok2;
    run_mode = 1'b1; rate_sel = 4'd15; step_btn = 1'b0; ch_sel = 2'd1;
    do_reset();
    wait_sel(8'h7F, ok);
    wait_sel(8'hFE, ok2);
    checks++; if (!(ok && ok2)) begin errors++; $display("FAIL scan_sync got=%b%b exp=11", ok, ok2); end
    for (int d = 0; d < 8; d++) begin
      repeat (8) @(negedge clk_in);
      es = 8'h01 << d;
      es = ~es;
      checks++; if (o_sel !== es) begin errors++; $display("FAIL scan_sel d%0d got=%h exp=%h", d, o_sel, es); end
      checks++; if (o_seg !== exp_seg[d]) begin errors++; $display("FAIL scan_seg d%0d got=%h exp=%h", d, o_seg, exp_seg[d]); end
      repeat (8) @(negedge clk_in);
    end
    ch_sel = 2'd3;
    wait_sel(8'hFE, ok);
    repeat (4) @(negedge clk_in);
    checks++; if (!ok || o_seg !== 8'hC0) begin errors++; $display("FAIL blank_d0 got=%h exp=c0", o_seg); end
    wait_sel(8'h7F, ok);
    repeat (4) @(negedge clk_in);
    checks++; if (!ok || o_seg !== 8'hC0) begin errors++; $display("FAIL blank_d7 got=%h exp=c0", o_seg); end
  endtask

  task automatic test_wrap_and_reset();
    int n, c;
    bit ok;
    run_mode = 1'b0; step_btn = 1'b0; rate_sel = 4'd0; ch_sel = 2'd2;
    do_reset();
    repeat (4) @(negedge clk_in);
    force dut.cyc_q = 32'hFFFFFFFF;
    #1 release dut.cyc_q;
    wait_sel(8'hFE, ok);
    repeat (4) @(negedge clk_in);
    checks++; if (!ok || o_seg !== 8'h8E) begin errors++; $display("FAIL cyc_display got=%h exp=8e", o_seg); end
    step_btn = 1'b1;
    wait_pulse(40, n);
    checks++; if (n != 11) begin errors++; $display("FAIL wrap_press got=%0d exp=11", n); end
    @(negedge clk_in);
    checks++; if (cycle_cnt !== 32'h0) begin errors++; $display("FAIL cyc_wrap got=%h exp=0", cycle_cnt); end
    step_btn = 1'b0;
    count_pulses(30, c);
    run_mode = 1'b1;
    wait_pulse(40, n);
    checks++; if (n != 18) begin errors++; $display("FAIL step_to_run got=%0d exp=18", n); end
    repeat (7) @(negedge clk_in);
    reset = 1'b0;
    #1;
    checks++; if (cpu_clk_en !== 1'b0) begin errors++; $display("FAIL midrst_en got=%b exp=0", cpu_clk_en); end
    checks++; if (cycle_cnt !== 32'h0) begin errors++; $display("FAIL midrst_cyc got=%h exp=0", cycle_cnt); end
    checks++; if (o_seg !== 8'hFF) begin errors++; $display("FAIL midrst_seg got=%h exp=ff", o_seg); end
    checks++; if (o_sel !== 8'hFF) begin errors++; $display("FAIL midrst_sel got=%h exp=ff", o_sel); end
    @(negedge clk_in);
    reset = 1'b1;
    wait_pulse(40, n);
    checks++; if (n != 18) begin errors++; $display("FAIL midrst_resume got=%0d exp=18", n); end
  endtask

  initial begin
    reset = 1'b0; run_mode = 1'b0; step_btn = 1'b0; rate_sel = '0; ch_sel = '0; ch_data = '0;
    @(negedge clk_in);
    test_reset();
    test_run_rate();
    test_step_debounce();
    test_held_switch();
    test_display();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
